// File: rtl/systolic_operand_feeder.sv
// ---------------------------------------------------------------------------
// systolic_operand_feeder
//
// Purpose:
//   Accepts operand beats (A vector, B vector, last-of-tile tag) over a
//   valid/ready handshake, buffers them in a small FIFO and issues them to
//   the systolic array one per cycle. After the closing beat of a tile is
//   issued, issue is held off for DRAIN_CYCLES cycles so the drain array can
//   unload results before the next tile's beats enter the array.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active-low
//   op_valid_i   operand beat valid
//   op_ready_o   feeder can accept a beat (FIFO not full)
//   op_a_i       A vector, lane i = bits [i*DATA_W +: DATA_W]
//   op_b_i       B vector, same packing as op_a_i
//   op_last_i    beat is the final k-step of its tile
//   en_o         a_o/b_o carry a valid beat this cycle
//   last_o       issued beat closes its tile (only with en_o)
//   a_o, b_o     issued operand vectors, zero when en_o is low
//   busy_o       FIFO non-empty or a tile is streaming/draining
//   tile_done_o  one-cycle pulse when the drain window completes
// ---------------------------------------------------------------------------
module systolic_operand_feeder #(
    parameter int SIZE         = 4,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 2*SIZE+5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [SIZE*DATA_W-1:0] op_a_i,
    input  logic [SIZE*DATA_W-1:0] op_b_i,
    input  logic                   op_last_i,
    output logic                   en_o,
    output logic                   last_o,
    output logic [SIZE*DATA_W-1:0] a_o,
    output logic [SIZE*DATA_W-1:0] b_o,
    output logic                   busy_o,
    output logic                   tile_done_o
);
    localparam int VW = SIZE*DATA_W;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW:0]   DEPTH_C    = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DCNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    logic [VW-1:0] r_mem_a    [FIFO_DEPTH];
    logic [VW-1:0] r_mem_b    [FIFO_DEPTH];
    logic          r_mem_last [FIFO_DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    state_t        r_state;
    logic [CW-1:0] r_drain_cnt;

    logic          r_en_p1;
    logic          r_last_p1;
    logic [VW-1:0] r_a_p1;
    logic [VW-1:0] r_b_p1;
    logic          r_done_p1;

    logic          w_push;
    logic          w_pop;
    logic [VW-1:0] w_head_a;
    logic [VW-1:0] w_head_b;
    logic          w_head_last;

    // Ready depends only on the registered count, never on op_valid_i.
    assign op_ready_o  = (r_count < DEPTH_C);
    assign w_push      = op_valid_i & op_ready_o;
    assign w_pop       = (r_count != '0) & (r_state != DRAIN);
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];

    // ---- Stage p0: FIFO storage (data only, no reset) ----
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]    <= op_a_i;
            r_mem_b[r_wr_ptr]    <= op_b_i;
            r_mem_last[r_wr_ptr] <= op_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_en_p1     <= 1'b0;
            r_last_p1   <= 1'b0;
            r_a_p1      <= '0;
            r_b_p1      <= '0;
            r_done_p1   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            // ---- Stage p1: issue register; idle cycles drive zeros ----
            r_en_p1   <= w_pop;
            r_last_p1 <= w_pop & w_head_last;
            r_a_p1    <= w_pop ? w_head_a : '0;
            r_b_p1    <= w_pop ? w_head_b : '0;
            r_done_p1 <= 1'b0;

            case (r_state)
                // A one-beat tile popped from IDLE must go straight to DRAIN,
                // otherwise the next tile's first beat would follow at once.
                IDLE, STREAM: begin
                    if (w_pop) begin
                        if (w_head_last) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= DRAIN_LOAD;
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state   <= IDLE;
                        r_done_p1 <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DCNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign en_o        = r_en_p1;
    assign last_o      = r_last_p1;
    assign a_o         = r_a_p1;
    assign b_o         = r_b_p1;
    assign tile_done_o = r_done_p1;
    assign busy_o      = (r_count != '0) | (r_state != IDLE);

    a_last_needs_en: assert property (@(posedge clk_i) disable iff (!rst_ni)
        last_o |-> en_o);
    a_no_pop_in_drain: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == DRAIN) |-> !w_pop);
    // The closing beat is on the outputs during the first DRAIN cycle.
    a_drain_en_is_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((r_state == DRAIN) && en_o) |-> last_o);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_pop |-> (r_count != '0));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_push |-> (r_count < DEPTH_C));

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_operand_feeder
//
// Drives directed and randomized operand beats into systolic_operand_feeder
// and compares every output, every cycle, against a queue-based reference
// model: accepted beats are queued in order, a beat may be issued one cycle
// after it is popped, and after a closing beat is popped no further pop is
// allowed until DRAIN_CYCLES+1 cycles later.
// ---------------------------------------------------------------------------
module tb_systolic_operand_feeder;
    localparam int SIZE   = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int DRAIN  = 13;
    localparam int W      = SIZE*DATA_W;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         op_valid_i = 1'b0;
    logic         op_ready_o;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         op_last_i = 1'b0;
    logic         en_o;
    logic         last_o;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic         busy_o;
    logic         tile_done_o;

    always #5 clk_i = ~clk_i;

    systolic_operand_feeder #(
        .SIZE(SIZE), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_last_i(op_last_i),
        .en_o(en_o), .last_o(last_o), .a_o(a_o), .b_o(b_o),
        .busy_o(busy_o), .tile_done_o(tile_done_o)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } beat_t;

    beat_t        mq[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           drain_until = 0;
    int           done_cycle = -1;
    bit           in_tile = 1'b0;
    logic         exp_en = 1'b0;
    logic         exp_last = 1'b0;
    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;
    bit           have_last = 1'b0;
    int           last_c = 0;
    int           last_gap = -1;
    bit           saw_not_ready = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        chk("en", W'(en_o), W'(exp_en));
        chk("last", W'(last_o), W'(exp_last));
        chk("a", a_o, exp_a);
        chk("b", b_o, exp_b);
        chk("tile_done", W'(tile_done_o), W'(cyc == done_cycle));
        chk("busy", W'(busy_o), W'(mq.size() != 0 || in_tile || cyc < drain_until));
        if (en_o && have_last) begin
            last_gap  = cyc - last_c - 1;
            have_last = 1'b0;
            chk("drain_gap_min", W'(last_gap >= DRAIN), W'(1));
        end
        if (last_o) begin
            have_last = 1'b1;
            last_c    = cyc;
        end
    endtask

    task automatic send(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit l, output bit acc);
        bit    rdy;
        bit    pop;
        beat_t bt;
        rdy = (mq.size() < DEPTH);
        chk("ready", W'(op_ready_o), W'(rdy));
        if (!op_ready_o) saw_not_ready = 1'b1;
        op_valid_i = v;
        op_a_i     = a;
        op_b_i     = b;
        op_last_i  = l;
        pop = (mq.size() != 0) && (cyc >= drain_until);
        acc = v && rdy;
        exp_en = 1'b0; exp_last = 1'b0; exp_a = '0; exp_b = '0;
        if (pop) begin
            bt       = mq.pop_front();
            exp_en   = 1'b1;
            exp_last = bt.last;
            exp_a    = bt.a;
            exp_b    = bt.b;
            if (bt.last) begin
                in_tile     = 1'b0;
                drain_until = cyc + 1 + DRAIN;
                done_cycle  = drain_until;
            end else begin
                in_tile = 1'b1;
            end
        end
        if (acc) begin
            bt.a = a; bt.b = b; bt.last = l;
            mq.push_back(bt);
        end
        step();
    endtask

    task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit l);
        bit acc;
        send(v, a, b, l, acc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        op_valid_i = 1'b0;
        op_last_i  = 1'b0;
        mq.delete();
        in_tile     = 1'b0;
        drain_until = 0;
        done_cycle  = -1;
        have_last   = 1'b0;
        exp_en = 1'b0; exp_last = 1'b0; exp_a = '0; exp_b = '0;
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ha;
        logic [W-1:0] hb;
        logic [W-1:0] lanes;
        bit           hl;
        bit           hv;
        bit           acc;
        int           sent;

        do_reset();
        idle(2);

        // Back-to-back 3-beat tile.
        for (int i = 0; i < 3; i++) drive(1'b1, rnd(), rnd(), i == 2);
        idle(20);

        // Two 2-beat tiles streamed continuously: gap must be exactly DRAIN.
        last_gap = -1;
        for (int i = 0; i < 4; i++) drive(1'b1, rnd(), rnd(), (i % 2) == 1);
        idle(25);
        chk("gap_exact", W'(last_gap), W'(DRAIN));

        // Gap in op_valid_i mid-tile.
        drive(1'b1, rnd(), rnd(), 1'b0);
        idle(2);
        drive(1'b1, rnd(), rnd(), 1'b1);
        idle(20);

        // Single-beat tile with lanes 1..4.
        lanes = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        drive(1'b1, lanes, rnd(), 1'b1);
        idle(20);

        // op_valid_i held high through drains; beats held until accepted.
        saw_not_ready = 1'b0;
        sent = 0;
        ha = rnd(); hb = rnd(); hl = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(1'b1, ha, hb, hl, acc);
            if (acc) begin
                sent++;
                ha = rnd(); hb = rnd(); hl = (sent % 3) == 0;
            end
        end
        chk("ready_fell", W'(saw_not_ready), W'(1));
        idle(40);

        // Reset during DRAIN with two beats buffered.
        drive(1'b1, rnd(), rnd(), 1'b1);
        drive(1'b1, rnd(), rnd(), 1'b0);
        drive(1'b1, rnd(), rnd(), 1'b1);
        idle(3);
        do_reset();
        idle(20);

        // Randomized traffic with occasional reset.
        hv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                hv = 1'b0;
            end else begin
                if (!hv) begin
                    hv = ($urandom % 4) != 0;
                    ha = rnd(); hb = rnd(); hl = ($urandom % 3) == 0;
                end
                send(hv, ha, hb, hl, acc);
                if (acc || !hv) hv = 1'b0;
            end
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
